// File: rtl/xor_arbiter.sv
// Two-port round-robin arbiter feeding a single registered XOR result slot.
// The slot refills in the same edge it drains, so transfers can run back to back.
//
//  state | meaning
//  ------+--------------------------------------------------
//  EMPTY | result slot holds no undelivered result
//  FULL  | out_y/out_id hold a result waiting for out_ready
module xor_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_y,
    output logic             out_id,
    input  logic             out_ready,
    output logic [7:0]       done_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             id_q, id_d;
    logic             last_id_q, last_id_d;
    logic [7:0]       done_q, done_d;
    logic             can_accept;
    logic             deliver;
    logic             g0, g1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            y_q       <= '0;
            id_q      <= 1'b0;
            last_id_q <= 1'b1;
            done_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            id_q      <= id_d;
            last_id_q <= last_id_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        can_accept = (state_q == EMPTY) || out_ready;
        deliver    = (state_q == FULL) && out_ready;
        // Grants are gated by rst_n so nothing is offered while reset is held.
        g0 = rst_n && can_accept && req0 && (!req1 || last_id_q);
        g1 = rst_n && can_accept && req1 && (!req0 || !last_id_q);

        state_d   = state_q;
        y_d       = y_q;
        id_d      = id_q;
        last_id_d = last_id_q;
        done_d    = done_q;

        if (g0) begin
            y_d       = a0 ^ b0;
            id_d      = 1'b0;
            last_id_d = 1'b0;
            state_d   = FULL;
        end else if (g1) begin
            y_d       = a1 ^ b1;
            id_d      = 1'b1;
            last_id_d = 1'b1;
            state_d   = FULL;
        end else if (deliver) begin
            state_d = EMPTY;
        end

        if (deliver) begin
            done_d = done_q + 8'd1;
        end
    end

    assign gnt0      = g0;
    assign gnt1      = g1;
    assign out_valid = (state_q == FULL);
    assign out_y     = y_q;
    assign out_id    = id_q;
    assign done_cnt  = done_q;

endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0  input  1  requester 0 has an operand pair pending.
REQ-005 a0, b0  input  WIDTH each  requester 0 operands.
REQ-006 gnt0  output  1  requester 0 operands accepted this cycle.
REQ-007 req1  input  1  requester 1 has an operand pair pending.
REQ-008 a1, b1  input  WIDTH each  requester 1 operands.
REQ-009 gnt1  output  1  requester 1 operands accepted this cycle.
REQ-010 out_valid  output  1  result register holds an undelivered result.
REQ-011 out_y  output  WIDTH  bitwise XOR result.
REQ-012 out_id  output  1  requester that owns out_y: 0 or 1.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.
REQ-014 done_cnt  output  8  count of delivered results.

Function
REQ-015 State machine with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 The result slot can accept a new request when state is EMPTY, or when state is FULL and out_ready=1.
REQ-017 gnt0/gnt1 are combinational and asserted only in cycles where the slot can accept and the corresponding req is high.
REQ-018 gnt0 and gnt1 are mutually exclusive; at most one is high per cycle.
REQ-019 Single request: the requesting port is granted.
REQ-020 Both requests: the port not recorded in last_id is granted (round-robin).
REQ-021 last_id updates to the granted port on every grant; last_id resets to 1, so port 0 wins the first contention.
REQ-022 Granted operands are registered at the clock edge: out_y = a^b of the granted port, out_id = granted port, and out_valid=1 on the next cycle (latency 1).
REQ-023 FULL with out_ready=0: out_y and out_id are held stable, no grant is issued, and the state stays FULL.
REQ-024 FULL with out_ready=1 and a grant: the new result replaces the old one in the same edge, and the state stays FULL (back-to-back transfers, no bubble).
REQ-025 FULL with out_ready=1 and no request: the state returns to EMPTY and out_valid=0.
REQ-026 EMPTY: out_ready is ignored and done_cnt does not change.
REQ-027 done_cnt increments by 1 on each edge where out_valid=1 and out_ready=1.
REQ-028 done_cnt wraps from 255 to 0 without saturating.
REQ-029 A requester holds req and its operands until it sees its gnt; operand changes before gnt are not captured.
REQ-030 out_y in EMPTY retains its last value; consumers qualify it with out_valid only.

Reset
REQ-031 rst_n=0 forces out_valid=0, out_y=0, out_id=0, done_cnt=0, last_id=1 and state=EMPTY immediately, without waiting for a clock edge.
REQ-032 While rst_n=0, gnt0=0 and gnt1=0.
REQ-033 Reset asserted while FULL discards the held result; done_cnt does not count it.
REQ-034 Operation resumes on the first rising edge after rst_n deasserts.

Verification
REQ-035 Reset, then req0=1, a0=8'h0F, b0=8'hFF, out_ready=1 -> gnt0=1 in that cycle; next cycle out_valid=1, out_y=8'hF0, out_id=0; done_cnt=1 one cycle later.
REQ-036 req0=req1=1 continuously, out_ready=1, four cycles -> grants alternate 0,1,0,1 starting at port 0; out_id sequence 0,1,0,1 with no idle cycle; done_cnt=4.
REQ-037 Result FULL with out_y=8'hAA, out_ready=0 for 3 cycles with req1 high -> gnt1=0 throughout; out_y=8'hAA and out_valid=1 held; done_cnt unchanged.
REQ-038 Drive 256 single transfers -> done_cnt returns to 0 on the 256th handshake.
REQ-039 Assert rst_n=0 mid-cycle while FULL -> out_valid and done_cnt drop to 0 before the next edge; after release, both ports requesting -> port 0 granted first.
REQ-040 All four bit-pair XOR cases (a,b = 0/0, 0/1, 1/0, 1/1 replicated across WIDTH) through each port -> out_y = 00, FF, FF, 00 (hex) with the correct out_id.
